// File: rtl/uart_fifo_tx.sv
// UART transmit engine: pops bytes from the TX FIFO and serializes them (start, 8 data LSB first, stop).
// Optional parity bit compiled in with `define UART_TX_PARITY_EN (adds parameter PARITY_ODD).
module uart_fifo_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
  ,parameter bit         PARITY_ODD   = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_pop,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shreg_q;
  logic          stop_q;
  logic          tx_q;
  logic          pop_q;
  logic          busy_q;
  logic          done_q;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
`endif

  logic can_start;
  assign can_start = en && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      pop_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (can_start) begin
            state_q <= S_POP;
            pop_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_POP: state_q <= S_LOAD;
        S_LOAD: begin
          shreg_q <= fifo_dout;
`ifdef UART_TX_PARITY_EN
          par_q   <= PARITY_ODD ? ~^fifo_dout : ^fifo_dout;
`endif
          tx_q    <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_START;
        end
        S_START: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            tx_q    <= shreg_q[0];
            bit_q   <= '0;
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              stop_q  <= 1'b0;
              state_q <= S_STOP;
`endif
            end else begin
              // tx is registered, so it takes the next bit before the shift lands
              shreg_q <= {1'b0, shreg_q[7:1]};
              tx_q    <= shreg_q[1];
              bit_q   <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            stop_q  <= 1'b0;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (stop_q == STOP_LAST) begin
              if (can_start) begin
                state_q <= S_POP;
                pop_q   <= 1'b1;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              stop_q <= stop_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            // registered pulse: raise one cycle early so it lands in the final clk
            if (stop_q == STOP_LAST && cnt_q == CNT_PRE) done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo_pop = pop_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;

endmodule
